// File: rtl/dram_req_scheduler.sv
// ============================================================================
// Module  : dram_req_scheduler
// Brief   : Buffers Datapath DRAM requests in a FIFO, issues them under a
//           valid/ready handshake with credit-limited outstanding requests.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dram_req_scheduler #(
    parameter int DEPTH           = 16,
    parameter int MAX_OUTSTANDING = 32,
    parameter int AFULL_MARGIN    = 4
) (
    input  logic        Clk_32UI,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [31:0] req_addr_k,
    input  logic [31:0] req_addr_l,
    output logic        stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr_k,
    output logic [31:0] mem_addr_l,
    input  logic        DRAM_get,
    output logic [5:0]  outstanding,
    output logic [4:0]  fifo_count,
    output logic        err,
    output logic        idle
);

    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = 1;
    localparam logic [4:0]         c_DEPTH    = 5'(DEPTH);
    localparam logic [4:0]         c_STALL_TH = 5'(DEPTH - AFULL_MARGIN);
    localparam logic [5:0]         c_MAX_OUT  = 6'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_mem_k [DEPTH];
    logic [31:0]         r_mem_l [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [4:0]          r_count;
    logic [5:0]          r_outstanding;
    logic                r_stall;
    logic                r_err;
    logic                r_idle;

    logic                w_full;
    logic                w_fire;
    logic                w_push;
    logic                w_get_ok;
    logic                w_err_set;
    logic [4:0]          w_count_nxt;
    logic [5:0]          w_out_nxt;

    assign w_full        = (r_count == c_DEPTH);
    assign mem_req_valid = (r_count != 5'd0) && (r_state == ST_RUN);
    assign w_fire        = mem_req_valid & mem_req_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push        = req_valid & (~w_full | w_fire);
    assign w_get_ok      = DRAM_get & (r_outstanding != 6'd0);
    assign w_err_set     = (req_valid & w_full & ~w_fire) | (DRAM_get & (r_outstanding == 6'd0));
    assign w_count_nxt   = r_count + 5'(w_push) - 5'(w_fire);
    assign w_out_nxt     = r_outstanding + 6'(w_fire) - 6'(w_get_ok);

    assign mem_addr_k    = r_mem_k[r_rd_ptr];
    assign mem_addr_l    = r_mem_l[r_rd_ptr];
    assign stall         = r_stall;
    assign outstanding   = r_outstanding;
    assign fifo_count    = r_count;
    assign err           = r_err;
    assign idle          = r_idle;

    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_k[i] <= '0;
                r_mem_l[i] <= '0;
            end
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_stall       <= 1'b0;
            r_err         <= 1'b0;
            r_idle        <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem_k[r_wr_ptr] <= req_addr_k;
                r_mem_l[r_wr_ptr] <= req_addr_l;
                r_wr_ptr          <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_fire) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count       <= w_count_nxt;
            r_outstanding <= w_out_nxt;
            r_stall       <= (w_count_nxt >= c_STALL_TH);
            r_idle        <= (w_count_nxt == 5'd0) && (w_out_nxt == 6'd0);
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // HOLD releases on any accepted response; the freed credit is used next cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:  if (w_out_nxt == c_MAX_OUT) w_state_nxt = ST_HOLD;
            ST_HOLD: if (w_get_ok)               w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_dram_req_scheduler.sv
// ============================================================================
// Module  : tb_dram_req_scheduler
// Brief   : Directed scoreboard bench for dram_req_scheduler.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dram_req_scheduler;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic [31:0] req_addr_k;
    logic [31:0] req_addr_l;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr_k;
    logic [31:0] mem_addr_l;
    logic        DRAM_get;
    logic [5:0]  outstanding;
    logic [4:0]  fifo_count;
    logic        err;
    logic        idle;

    logic [63:0] exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_fire   = 0;

    dram_req_scheduler dut (
        .Clk_32UI      (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_addr_k    (req_addr_k),
        .req_addr_l    (req_addr_l),
        .stall         (stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr_k    (mem_addr_k),
        .mem_addr_l    (mem_addr_l),
        .DRAM_get      (DRAM_get),
        .outstanding   (outstanding),
        .fifo_count    (fifo_count),
        .err           (err),
        .idle          (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at posedge+1, so values at negedge are those seen by the next edge.
    always @(negedge clk) begin
        if (reset_n && mem_req_valid && mem_req_ready) begin
            logic [63:0] e;
            n_fire++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL issue_unexpected: got k=%h l=%h, required no issue", mem_addr_k, mem_addr_l);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr_k, mem_addr_l} !== e) begin
                    n_errors++;
                    $display("FAIL issue_addr: got k=%h l=%h, required k=%h l=%h",
                             mem_addr_k, mem_addr_l, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] k, input logic [31:0] l, input bit accepted);
        req_valid  = 1'b1;
        req_addr_k = k;
        req_addr_l = l;
        if (accepted) exp_q.push_back({k, l});
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        exp_q.delete();
        n_fire = 0;
        reset_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_valid"}, 32'(mem_req_valid), 32'd0);
        chk({tag, "_addr_k"}, mem_addr_k, 32'd0);
        chk({tag, "_addr_l"}, mem_addr_l, 32'd0);
        chk({tag, "_outst"}, 32'(outstanding), 32'd0);
        chk({tag, "_count"}, 32'(fifo_count), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_idle"}, 32'(idle), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        req_valid     = 1'b0;
        req_addr_k    = '0;
        req_addr_l    = '0;
        mem_req_ready = 1'b0;
        DRAM_get      = 1'b0;
        #12;
        reset_n = 1'b1;
        chk_reset_vals("rst");

        // 1) single request, latency 1
        mem_req_ready = 1'b1;
        drive_req(32'h100, 32'h200, 1'b1);
        chk("t1_valid", 32'(mem_req_valid), 32'd1);
        chk("t1_addr_k", mem_addr_k, 32'h100);
        chk("t1_addr_l", mem_addr_l, 32'h200);
        tick();
        chk("t1_outst", 32'(outstanding), 32'd1);
        chk("t1_count", 32'(fifo_count), 32'd0);
        DRAM_get = 1'b1;
        tick();
        DRAM_get = 1'b0;
        chk("t1_outst_back", 32'(outstanding), 32'd0);
        chk("t1_idle", 32'(idle), 32'd1);

        // 2) fill with no ready: stall threshold, full, overflow
        mem_req_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive_req(32'h500 + 32'(i), 32'h600 + 32'(i), 1'b1);
            if (i == 10) chk("t2_stall_11", 32'(stall), 32'd0);
        end
        chk("t2_stall_12", 32'(stall), 32'd1);
        chk("t2_count_12", 32'(fifo_count), 32'd12);
        for (int i = 12; i < 16; i++) drive_req(32'h500 + 32'(i), 32'h600 + 32'(i), 1'b1);
        chk("t2_count_16", 32'(fifo_count), 32'd16);
        chk("t2_err_full", 32'(err), 32'd0);
        chk("t2_stall_16", 32'(stall), 32'd1);
        drive_req(32'hDEAD, 32'hBEEF, 1'b0);
        chk("t2_err_ovf", 32'(err), 32'd1);
        chk("t2_count_ovf", 32'(fifo_count), 32'd16);
        do_reset();

        // 3) credit limit: 40 requests, 32 issued, then one per returned credit
        mem_req_ready = 1'b1;
        for (int i = 0; i < 40; i++) drive_req(32'h1000 + 32'(i), 32'h2000 + 32'(i), 1'b1);
        repeat (3) tick();
        chk("t3_fires", 32'(n_fire), 32'd32);
        chk("t3_outst", 32'(outstanding), 32'd32);
        chk("t3_hold_valid", 32'(mem_req_valid), 32'd0);
        chk("t3_count", 32'(fifo_count), 32'd8);
        DRAM_get = 1'b1;
        tick();
        DRAM_get = 1'b0;
        repeat (3) tick();
        chk("t3_fires_after", 32'(n_fire), 32'd33);
        chk("t3_outst_after", 32'(outstanding), 32'd32);
        chk("t3_count_after", 32'(fifo_count), 32'd7);
        chk("t3_hold_again", 32'(mem_req_valid), 32'd0);
        do_reset();

        // 4) full FIFO with push+pop every cycle
        mem_req_ready = 1'b0;
        for (int i = 0; i < 16; i++) drive_req(32'h3000 + 32'(i), 32'h4000 + 32'(i), 1'b1);
        chk("t4_full", 32'(fifo_count), 32'd16);
        mem_req_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_req(32'h5000 + 32'(i), 32'h6000 + 32'(i), 1'b1);
            if (i % 5 == 4) chk("t4_count", 32'(fifo_count), 32'd16);
        end
        mem_req_ready = 1'b0;
        chk("t4_err", 32'(err), 32'd0);
        chk("t4_outst", 32'(outstanding), 32'd20);
        chk("t4_fires", 32'(n_fire), 32'd20);
        do_reset();

        // 5) underflow DRAM_get, then fire+get in same cycle
        DRAM_get = 1'b1;
        tick();
        DRAM_get = 1'b0;
        chk("t5_err_underflow", 32'(err), 32'd1);
        chk("t5_outst_zero", 32'(outstanding), 32'd0);
        mem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) drive_req(32'h7000 + 32'(i), 32'h8000 + 32'(i), 1'b1);
        tick();
        chk("t5_outst_5", 32'(outstanding), 32'd5);
        drive_req(32'h7777, 32'h8888, 1'b1);
        DRAM_get = 1'b1;
        tick();
        DRAM_get = 1'b0;
        chk("t5_outst_same", 32'(outstanding), 32'd5);
        chk("t5_count", 32'(fifo_count), 32'd0);
        mem_req_ready = 1'b0;
        do_reset();

        // 6) async reset mid-burst
        for (int i = 0; i < 16; i++) begin
            mem_req_ready = (i <= 9);
            drive_req(32'h9000 + 32'(i), 32'hA000 + 32'(i), 1'b1);
        end
        mem_req_ready = 1'b0;
        chk("t6_count", 32'(fifo_count), 32'd7);
        chk("t6_outst", 32'(outstanding), 32'd9);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("t6_async");
        exp_q.delete();
        #1;
        reset_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
